// File: rtl/fir_fold_ctrl_if.sv
// Control/address bundle between the folded-FIR sequencer and its stream source / datapath.
interface fir_fold_ctrl_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              ValidIn;
    logic              ReadyIn;
    logic              Clear;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_waddr;
    logic [ADDR_W-1:0] buf_raddr;
    logic [ADDR_W-1:0] coef_addr;
    logic              tap_zero;
    logic              mac_en;
    logic              mac_clr;
    logic              out_latch;
    logic              ValidOut;

    modport master (
        input  ValidIn, Clear,
        output ReadyIn, buf_we, buf_waddr, buf_raddr, coef_addr,
               tap_zero, mac_en, mac_clr, out_latch, ValidOut
    );

    modport slave (
        output ValidIn, Clear,
        input  ReadyIn, buf_we, buf_waddr, buf_raddr, coef_addr,
               tap_zero, mac_en, mac_clr, out_latch, ValidOut
    );
endinterface

// File: rtl/fir_fold_ctrl.sv
// Sequencer for a folded FIR: accepts one sample, issues TAPS MAC cycles over the
// circular sample buffer, waits out the MAC pipeline and strobes the result.
module fir_fold_ctrl #(
    parameter int unsigned TAPS    = 16,
    parameter int unsigned MAC_LAT = 2,
    parameter int unsigned ADDR_W  = $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             i_rst_n,
    fir_fold_ctrl_if.master  bus
);
    localparam int unsigned FILL_W  = $clog2(TAPS + 1);
    localparam int unsigned DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam int unsigned DIFF_W  = ADDR_W + 1;

    localparam logic [ADDR_W-1:0]  LAST_TAP   = ADDR_W'(TAPS - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
    localparam logic [FILL_W-1:0]  FILL_MAX   = FILL_W'(TAPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state,     w_state_nxt;
    logic [ADDR_W-1:0]   r_wptr,      w_wptr_nxt;
    logic [ADDR_W-1:0]   r_base,      w_base_nxt;
    logic [ADDR_W-1:0]   r_tap_cnt,   w_tap_cnt_nxt;
    logic [DRAIN_W-1:0]  r_drain_cnt, w_drain_cnt_nxt;
    logic [FILL_W-1:0]   r_filled,    w_filled_nxt;
    logic                r_ready_en;

    logic                w_ready;
    logic                w_accept;
    logic [DIFF_W-1:0]   w_wrap_diff;
    logic [ADDR_W-1:0]   w_raddr;
    logic                w_mac_en;
    logic                w_mac_clr;
    logic                w_tap_zero;
    logic                w_done;

    // ReadyIn stays low through reset and rises on the first edge after release.
    assign w_ready  = r_ready_en & (r_state == S_IDLE) & ~bus.Clear;
    assign w_accept = w_ready & bus.ValidIn;

    // Newest sample sits at base; tap k reads (base - k) mod TAPS without relying on power-of-2 wrap.
    assign w_wrap_diff = {1'b0, r_base} + DIFF_W'(TAPS) - {1'b0, r_tap_cnt};
    assign w_raddr     = (r_base >= r_tap_cnt) ? (r_base - r_tap_cnt) : ADDR_W'(w_wrap_diff);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_base      <= '0;
            r_tap_cnt   <= '0;
            r_drain_cnt <= '0;
            r_filled    <= '0;
            r_ready_en  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wptr      <= w_wptr_nxt;
            r_base      <= w_base_nxt;
            r_tap_cnt   <= w_tap_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_filled    <= w_filled_nxt;
            r_ready_en  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wptr_nxt      = r_wptr;
        w_base_nxt      = r_base;
        w_tap_cnt_nxt   = r_tap_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        w_filled_nxt    = r_filled;
        w_mac_en        = 1'b0;
        w_mac_clr       = 1'b0;
        w_tap_zero      = 1'b0;
        w_done          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_base_nxt    = r_wptr;
                    w_wptr_nxt    = (r_wptr == LAST_TAP) ? '0 : r_wptr + ADDR_W'(1);
                    w_filled_nxt  = (r_filled == FILL_MAX) ? r_filled : r_filled + FILL_W'(1);
                    w_tap_cnt_nxt = '0;
                    w_state_nxt   = S_RUN;
                end else if (bus.Clear) begin
                    w_wptr_nxt   = '0;
                    w_filled_nxt = '0;
                end
            end
            S_RUN: begin
                w_mac_en   = 1'b1;
                w_mac_clr  = (r_tap_cnt == '0);
                w_tap_zero = (FILL_W'(r_tap_cnt) >= r_filled);
                if (r_tap_cnt == LAST_TAP) begin
                    w_drain_cnt_nxt = '0;
                    w_state_nxt     = (MAC_LAT == 0) ? S_DONE : S_DRAIN;
                end else begin
                    w_tap_cnt_nxt = r_tap_cnt + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == LAST_DRAIN) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + DRAIN_W'(1);
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.ReadyIn   = w_ready;
    assign bus.buf_we    = w_accept;
    assign bus.buf_waddr = r_wptr;
    assign bus.buf_raddr = w_mac_en ? w_raddr : '0;
    assign bus.coef_addr = w_mac_en ? r_tap_cnt : '0;
    assign bus.tap_zero  = w_tap_zero;
    assign bus.mac_en    = w_mac_en;
    assign bus.mac_clr   = w_mac_clr;
    assign bus.out_latch = w_done;
    assign bus.ValidOut  = w_done;
endmodule

// File: tb/tb_fir_fold_ctrl.sv
// Random-stimulus bench for fir_fold_ctrl: two configurations (4 taps / latency 2, 5 taps / latency 0)
// checked every cycle against a transaction-timeline model.
module tb_fir_fold_ctrl;
    localparam int unsigned T0 = 4, L0 = 2, A0 = 2;
    localparam int unsigned T1 = 5, L1 = 0, A1 = 3;
    localparam int NCYC = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_fold_ctrl_if #(.ADDR_W(A0)) bus0 ();
    fir_fold_ctrl_if #(.ADDR_W(A1)) bus1 ();

    fir_fold_ctrl #(.TAPS(T0), .MAC_LAT(L0), .ADDR_W(A0)) u_dut0 (.clk(clk), .i_rst_n(rst_n), .bus(bus0));
    fir_fold_ctrl #(.TAPS(T1), .MAC_LAT(L1), .ADDR_W(A1)) u_dut1 (.clk(clk), .i_rst_n(rst_n), .bus(bus1));

    typedef struct {
        int rdy, we, waddr, raddr, coef, tz, en, clr, latch, vo;
    } obs_t;

    int n_chk = 0;
    int n_bad = 0;

    // Model: m_p = cycles since the accepting edge (-1 when idle).
    int m_t[2]      = '{int'(T0), int'(T1)};
    int m_l[2]      = '{int'(L0), int'(L1)};
    int m_p[2]      = '{-1, -1};
    int m_wptr[2]   = '{0, 0};
    int m_base[2]   = '{0, 0};
    int m_filled[2] = '{0, 0};
    bit m_rdy[2]    = '{1'b0, 1'b0};
    int n_acc[2]    = '{0, 0};
    int n_abort[2]  = '{0, 0};
    int n_vout[2]   = '{0, 0};

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t get_obs(input int c);
        obs_t o;
        if (c == 0) begin
            o.rdy = int'(bus0.ReadyIn);   o.we = int'(bus0.buf_we);     o.waddr = int'(bus0.buf_waddr);
            o.raddr = int'(bus0.buf_raddr); o.coef = int'(bus0.coef_addr); o.tz = int'(bus0.tap_zero);
            o.en = int'(bus0.mac_en);     o.clr = int'(bus0.mac_clr);   o.latch = int'(bus0.out_latch);
            o.vo = int'(bus0.ValidOut);
        end else begin
            o.rdy = int'(bus1.ReadyIn);   o.we = int'(bus1.buf_we);     o.waddr = int'(bus1.buf_waddr);
            o.raddr = int'(bus1.buf_raddr); o.coef = int'(bus1.coef_addr); o.tz = int'(bus1.tap_zero);
            o.en = int'(bus1.mac_en);     o.clr = int'(bus1.mac_clr);   o.latch = int'(bus1.out_latch);
            o.vo = int'(bus1.ValidOut);
        end
        return o;
    endfunction

    task automatic check_cfg(input int c, input bit v, input bit cl, input bit in_rst, input bit rel);
        obs_t  o;
        int    t, l, p, k, exp_rdy;
        string s;
        o = get_obs(c);
        t = m_t[c]; l = m_l[c]; p = m_p[c];
        s = $sformatf("c%0d_", c);
        if (o.vo != 0) n_vout[c]++;
        if (in_rst) begin
            chk({s, "rst_rdy"}, o.rdy, 0);
            chk({s, "rst_we"},  o.we, 0);
            chk({s, "rst_en"},  o.en, 0);
            chk({s, "rst_vo"},  o.vo, 0);
            chk({s, "rst_latch"}, o.latch, 0);
            chk({s, "rst_clr"}, o.clr, 0);
            return;
        end
        if (p < 0) begin
            exp_rdy = (m_rdy[c] && !cl) ? 1 : 0;
            if (!rel) chk({s, "rdy"}, o.rdy, exp_rdy);
            chk({s, "we"}, o.we, (v && exp_rdy != 0) ? 1 : 0);
            if (v && exp_rdy != 0) chk({s, "waddr"}, o.waddr, m_wptr[c]);
            chk({s, "idle_en"}, o.en, 0);
            chk({s, "idle_vo"}, o.vo, 0);
            chk({s, "idle_latch"}, o.latch, 0);
        end else if (p <= t) begin
            k = p - 1;
            chk({s, "run_rdy"}, o.rdy, 0);
            chk({s, "run_we"},  o.we, 0);
            chk({s, "run_en"},  o.en, 1);
            chk({s, "coef"},    o.coef, k);
            chk({s, "raddr"},   o.raddr, (m_base[c] - k + t) % t);
            chk({s, "mac_clr"}, o.clr, (k == 0) ? 1 : 0);
            chk({s, "tap_zero"}, o.tz, (k >= m_filled[c]) ? 1 : 0);
            chk({s, "run_vo"},  o.vo, 0);
        end else if (p <= t + l) begin
            chk({s, "drain_rdy"}, o.rdy, 0);
            chk({s, "drain_en"},  o.en, 0);
            chk({s, "drain_vo"},  o.vo, 0);
            chk({s, "drain_latch"}, o.latch, 0);
        end else begin
            chk({s, "done_rdy"}, o.rdy, 0);
            chk({s, "done_en"},  o.en, 0);
            chk({s, "done_vo"},  o.vo, 1);
            chk({s, "done_latch"}, o.latch, 1);
        end
    endtask

    task automatic update_cfg(input int c, input bit v, input bit cl, input bit in_rst);
        int t;
        t = m_t[c];
        if (in_rst) begin
            if (m_p[c] > 0) n_abort[c]++;
            m_p[c] = -1; m_wptr[c] = 0; m_base[c] = 0; m_filled[c] = 0; m_rdy[c] = 1'b0;
            return;
        end
        if (m_p[c] < 0) begin
            if (m_rdy[c] && v && !cl) begin
                m_base[c]   = m_wptr[c];
                m_wptr[c]   = (m_wptr[c] + 1) % t;
                m_filled[c] = (m_filled[c] + 1 > t) ? t : m_filled[c] + 1;
                m_p[c]      = 1;
                n_acc[c]++;
            end else if (cl) begin
                m_wptr[c]   = 0;
                m_filled[c] = 0;
            end
        end else begin
            m_p[c]++;
            if (m_p[c] > t + m_l[c] + 1) m_p[c] = -1;
        end
        m_rdy[c] = 1'b1;
    endtask

    initial begin
        bit       v[2];
        bit       cl[2];
        bit       rel;
        bit       in_rst;
        bit       want_rst;
        bit       rst_hit;
        int       rst_left;
        int       act;

        rst_left = 3; want_rst = 1'b0; rst_hit = 1'b0; act = 0;
        bus0.ValidIn = 1'b0; bus0.Clear = 1'b0;
        bus1.ValidIn = 1'b0; bus1.Clear = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            rel = 1'b0;
            if (rst_left > 0) begin
                rst_n = 1'b0;
                rst_left--;
            end else if (!rst_n) begin
                rst_n = 1'b1;
                rel   = 1'b1;
            end else if (want_rst && m_p[0] >= 1 && m_p[0] <= int'(T0)) begin
                rst_n    = 1'b0;
                rst_left = 2;
                want_rst = 1'b0;
                rst_hit  = 1'b1;
            end
            in_rst = !rst_n;

            for (int c = 0; c < 2; c++) begin
                if (in_rst || rel) begin
                    v[c] = 1'b0; cl[c] = 1'b0;
                end else if (act == 0) begin
                    v[c] = 1'b1; cl[c] = 1'b1;
                end else if (act < 60) begin
                    v[c] = 1'b1; cl[c] = 1'b0;
                end else if (act < 900) begin
                    v[c]  = ($urandom_range(0, 3) != 0);
                    cl[c] = ($urandom_range(0, 15) == 0);
                end else begin
                    v[c] = 1'b0; cl[c] = 1'b0;
                end
            end
            if (!in_rst && !rel) begin
                if (act == 400) want_rst = 1'b1;
                act++;
            end

            bus0.ValidIn = v[0]; bus0.Clear = cl[0];
            bus1.ValidIn = v[1]; bus1.Clear = cl[1];
            #1;
            for (int c = 0; c < 2; c++) begin
                check_cfg(c, v[c], cl[c], in_rst, rel);
                update_cfg(c, v[c], cl[c], in_rst);
            end
        end

        chk("mid_run_reset_hit", int'(rst_hit), 1);
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("c%0d_idle_at_end", c), (m_p[c] < 0) ? 1 : 0, 1);
            chk($sformatf("c%0d_vout_count", c), n_vout[c], n_acc[c] - n_abort[c]);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
